// File: rtl/layer_compositor_if.sv
// ---------------------------------------------------------------------------
// layer_compositor_if
// Pixel and control bus of the layer compositor.
//
// Signals (directions as seen from the compositor, i.e. the slave modport):
//   frame_start  in   one-cycle pulse at the start of each frame
//   video_off    in   blanking, forces a black pixel
//   overlay_en   in   full-screen overlay active
//   overlay_rgb  in   overlay colour
//   layer_on     in   per-layer pixel-covered flags
//   layer_rgb    in   per-layer colours, layer i at [i*RGB_W +: RGB_W]
//   bg_rgb       in   background colour
//   mask_in      in   requested layer enables (latched at frame_start)
//   blink_in     in   requested layer blink enables (latched at frame_start)
//   rgb_out      out  composited pixel
//   win_layer    out  index of the winning layer
//   win_valid    out  a game layer won this pixel
//   frame_cnt    out  8-bit wrapping frame counter
//
// The master modport is the pixel source / consumer side.
// ---------------------------------------------------------------------------
interface layer_compositor_if #(
    parameter int NUM_LAYERS = 6,
    parameter int RGB_W      = 12
);
    localparam int IDX_W = $clog2(NUM_LAYERS);

    logic                        frame_start;
    logic                        video_off;
    logic                        overlay_en;
    logic [RGB_W-1:0]            overlay_rgb;
    logic [NUM_LAYERS-1:0]       layer_on;
    logic [NUM_LAYERS*RGB_W-1:0] layer_rgb;
    logic [RGB_W-1:0]            bg_rgb;
    logic [NUM_LAYERS-1:0]       mask_in;
    logic [NUM_LAYERS-1:0]       blink_in;
    logic [RGB_W-1:0]            rgb_out;
    logic [IDX_W-1:0]            win_layer;
    logic                        win_valid;
    logic [7:0]                  frame_cnt;

    modport master (
        output frame_start, video_off, overlay_en, overlay_rgb,
               layer_on, layer_rgb, bg_rgb, mask_in, blink_in,
        input  rgb_out, win_layer, win_valid, frame_cnt
    );

    modport slave (
        input  frame_start, video_off, overlay_en, overlay_rgb,
               layer_on, layer_rgb, bg_rgb, mask_in, blink_in,
        output rgb_out, win_layer, win_valid, frame_cnt
    );
endinterface

// File: rtl/layer_compositor.sv
// ---------------------------------------------------------------------------
// layer_compositor
// Two-stage priority compositor for NUM_LAYERS sprite/game layers with a
// colour key, per-frame layer masking, per-layer blinking, a full-screen
// overlay and blanking. One pixel per clock, fixed two-cycle latency.
//
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   bus    layer_compositor_if.slave (pixel inputs, frame control, outputs)
//
// Stage 1 registers the per-layer eligibility vector together with all
// colours and the blank/overlay flags. Stage 2 picks the lowest-index
// eligible layer and registers rgb_out / win_layer / win_valid.
// ---------------------------------------------------------------------------
module layer_compositor #(
    parameter int               NUM_LAYERS = 6,
    parameter int               RGB_W      = 12,
    parameter logic [RGB_W-1:0] KEY_COLOR  = 12'hF0F,
    parameter int               BLINK_LOG2 = 3
) (
    input  logic            clk,
    input  logic            reset,
    layer_compositor_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_LAYERS);

    // Per-frame control state
    logic [NUM_LAYERS-1:0] mask_act;
    logic [NUM_LAYERS-1:0] blink_act;
    logic [7:0]            frame_cnt_q;

    // Stage 1 registers
    logic [NUM_LAYERS-1:0]       s1_elig;
    logic [NUM_LAYERS*RGB_W-1:0] s1_layer_rgb;
    logic [RGB_W-1:0]            s1_overlay_rgb;
    logic [RGB_W-1:0]            s1_bg_rgb;
    logic                        s1_video_off;
    logic                        s1_overlay_en;

    // Stage 2 registers
    logic [RGB_W-1:0] rgb_q;
    logic [IDX_W-1:0] win_layer_q;
    logic             win_valid_q;

    logic [NUM_LAYERS-1:0] elig;
    logic                  blink_phase;
    logic                  sel_found;
    logic [IDX_W-1:0]      sel_idx;
    logic [RGB_W-1:0]      sel_rgb;
    logic [RGB_W-1:0]      nxt_rgb;
    logic [IDX_W-1:0]      nxt_idx;
    logic                  nxt_valid;

    // Mask/blink requests are only adopted at frame boundaries so a layer
    // never changes visibility in the middle of a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_act    <= '1;
            blink_act   <= '0;
            frame_cnt_q <= 8'd0;
        end else if (bus.frame_start) begin
            mask_act    <= bus.mask_in;
            blink_act   <= bus.blink_in;
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    // Eligibility uses the current (pre-update) control state, so in the
    // frame_start cycle the old mask/blink/frame count still apply.
    // Counter bit BLINK_LOG2 toggles every 2^BLINK_LOG2 frames, which is
    // the blink half-period.
    always_comb begin
        blink_phase = frame_cnt_q[BLINK_LOG2];
        elig        = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            elig[i] = bus.layer_on[i] && mask_act[i]
                   && !(blink_act[i] && blink_phase)
                   && (bus.layer_rgb[i*RGB_W +: RGB_W] != KEY_COLOR);
        end
    end

    // Stage 1. Reset stores video_off=1 so the pipeline drains black.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_elig        <= '0;
            s1_layer_rgb   <= '0;
            s1_overlay_rgb <= '0;
            s1_bg_rgb      <= '0;
            s1_video_off   <= 1'b1;
            s1_overlay_en  <= 1'b0;
        end else begin
            s1_elig        <= elig;
            s1_layer_rgb   <= bus.layer_rgb;
            s1_overlay_rgb <= bus.overlay_rgb;
            s1_bg_rgb      <= bus.bg_rgb;
            s1_video_off   <= bus.video_off;
            s1_overlay_en  <= bus.overlay_en;
        end
    end

    // Priority select: scan from the lowest priority upward so the
    // lowest-index eligible layer is the last one written and wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_rgb   = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (s1_elig[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_rgb   = s1_layer_rgb[i*RGB_W +: RGB_W];
            end
        end
    end

    // Output mux: blanking beats overlay, overlay beats layers, layers beat
    // the background. Overlay and background bypass the colour key.
    always_comb begin
        nxt_rgb   = s1_bg_rgb;
        nxt_idx   = '0;
        nxt_valid = 1'b0;
        if (s1_video_off) begin
            nxt_rgb = '0;
        end else if (s1_overlay_en) begin
            nxt_rgb = s1_overlay_rgb;
        end else if (sel_found) begin
            nxt_rgb   = sel_rgb;
            nxt_idx   = sel_idx;
            nxt_valid = 1'b1;
        end
    end

    // Stage 2
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q       <= '0;
            win_layer_q <= '0;
            win_valid_q <= 1'b0;
        end else begin
            rgb_q       <= nxt_rgb;
            win_layer_q <= nxt_idx;
            win_valid_q <= nxt_valid;
        end
    end

    assign bus.rgb_out   = rgb_q;
    assign bus.win_layer = win_layer_q;
    assign bus.win_valid = win_valid_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_layer_compositor.sv
// ---------------------------------------------------------------------------
// tb_layer_compositor
// Directed bench for layer_compositor at default parameters. Stimulus pushes
// hand-computed expectations into scoreboard queues tagged with the cycle in
// which the DUT must present them; a separate monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_layer_compositor;

    localparam int NL = 6;
    localparam int RW = 12;

    typedef struct {
        int          due;
        int          tag;
        logic [11:0] rgb;
        logic [2:0]  idx;
        logic        valid;
    } pix_t;

    typedef struct {
        int         due;
        int         tag;
        logic [7:0] fc;
    } fc_t;

    logic clk;
    logic reset;
    int   cycle;
    int   checks;
    int   errors;
    int   tag_cnt;
    pix_t pix_q[$];
    fc_t  fc_q[$];
    logic [11:0] lc [NL];

    layer_compositor_if #(.NUM_LAYERS(NL), .RGB_W(RW)) bus ();

    layer_compositor #(
        .NUM_LAYERS(NL),
        .RGB_W(RW),
        .KEY_COLOR(12'hF0F),
        .BLINK_LOG2(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Packs the per-layer colour table, pushes the expected pixel for the
    // inputs now on the bus (seen two edges later) and advances one cycle.
    task automatic apply_stimulus(input bit chk, input logic [11:0] e_rgb,
                                  input logic [2:0] e_idx, input logic e_valid);
        pix_t p;
        for (int i = 0; i < NL; i++) bus.layer_rgb[i*RW +: RW] = lc[i];
        if (chk) begin
            p.due = cycle + 2; p.tag = tag_cnt; p.rgb = e_rgb;
            p.idx = e_idx; p.valid = e_valid;
            tag_cnt++;
            pix_q.push_back(p);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic frame_pulse(input logic [7:0] e_fc, input logic [11:0] e_rgb,
                               input logic [2:0] e_idx, input logic e_valid);
        fc_t f;
        bus.frame_start = 1'b1;
        f.due = cycle + 1; f.tag = tag_cnt; f.fc = e_fc;
        tag_cnt++;
        fc_q.push_back(f);
        apply_stimulus(1'b1, e_rgb, e_idx, e_valid);
        bus.frame_start = 1'b0;
    endtask

    // Reset with in-flight pixels discarded; checks reset outputs and the
    // black pixel drained from the cleared first stage.
    task automatic do_reset();
        pix_t p;
        fc_t  f;
        pix_q.delete();
        fc_q.delete();
        reset = 1'b1;
        p.due = cycle + 1; p.tag = tag_cnt; p.rgb = 12'h000; p.idx = 3'd0; p.valid = 1'b0;
        f.due = cycle + 1; f.tag = tag_cnt; f.fc = 8'd0;
        tag_cnt++;
        pix_q.push_back(p);
        fc_q.push_back(f);
        @(posedge clk);
        #1;
        reset = 1'b0;
        p.due = cycle + 1; p.tag = tag_cnt;
        tag_cnt++;
        pix_q.push_back(p);
    endtask

    task automatic check_output(input pix_t p);
        checks++;
        if (p.due != cycle || bus.rgb_out !== p.rgb || bus.win_layer !== p.idx
            || bus.win_valid !== p.valid) begin
            errors++;
            $display("[TB] FAIL pix#%0d cycle %0d (due %0d): rgb_out=%h win_layer=%0d win_valid=%0b, required rgb_out=%h win_layer=%0d win_valid=%0b",
                     p.tag, cycle, p.due, bus.rgb_out, bus.win_layer, bus.win_valid,
                     p.rgb, p.idx, p.valid);
        end
    endtask

    task automatic check_frame(input fc_t f);
        checks++;
        if (f.due != cycle || bus.frame_cnt !== f.fc) begin
            errors++;
            $display("[TB] FAIL frame_cnt#%0d cycle %0d (due %0d): got %0d, required %0d",
                     f.tag, cycle, f.due, bus.frame_cnt, f.fc);
        end
    endtask

    // Monitor: on each falling edge, compare everything that is due.
    initial begin
        forever begin
            @(negedge clk);
            while (pix_q.size() > 0 && pix_q[0].due <= cycle) check_output(pix_q.pop_front());
            while (fc_q.size() > 0 && fc_q[0].due <= cycle) check_frame(fc_q.pop_front());
        end
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: stimulus did not complete, cycle %0d", cycle);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic hidden;
        checks = 0; errors = 0; tag_cnt = 0;
        reset = 1'b1;
        bus.frame_start = 1'b0;
        bus.video_off   = 1'b0;
        bus.overlay_en  = 1'b0;
        bus.overlay_rgb = 12'h5A5;
        bus.bg_rgb      = 12'h123;
        bus.layer_on    = 6'b000000;
        bus.mask_in     = 6'b111111;
        bus.blink_in    = 6'b000000;
        lc[0] = 12'h0F0; lc[1] = 12'h00F; lc[2] = 12'h333;
        lc[3] = 12'hF00; lc[4] = 12'h444; lc[5] = 12'h555;
        for (int i = 0; i < NL; i++) bus.layer_rgb[i*RW +: RW] = lc[i];
        @(posedge clk); #1;
        @(posedge clk); #1;
        $display("[TB] reset and basic priority");
        do_reset();

        bus.layer_on = 6'b001010;
        apply_stimulus(1'b1, 12'h00F, 3'd1, 1'b1);
        lc[1] = 12'hF0F;
        apply_stimulus(1'b1, 12'hF00, 3'd3, 1'b1);
        bus.layer_on = 6'b000000;
        apply_stimulus(1'b1, 12'h123, 3'd0, 1'b0);

        // Every layer on but keyed out -> background
        bus.layer_on = 6'b111111;
        for (int i = 0; i < NL; i++) lc[i] = 12'hF0F;
        apply_stimulus(1'b1, 12'h123, 3'd0, 1'b0);
        lc[0] = 12'h0F0; lc[5] = 12'h555;
        apply_stimulus(1'b1, 12'h0F0, 3'd0, 1'b1);
        bus.layer_on = 6'b100000;
        apply_stimulus(1'b1, 12'h555, 3'd5, 1'b1);
        lc[2] = 12'h333; lc[4] = 12'h444;

        $display("[TB] overlay and blanking");
        lc[1] = 12'h00F; lc[3] = 12'hF00;
        bus.layer_on   = 6'b001010;
        bus.overlay_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.video_off = k[0];
            apply_stimulus(1'b1, k[0] ? 12'h000 : 12'h5A5, 3'd0, 1'b0);
        end
        bus.overlay_en = 1'b0;
        bus.video_off  = 1'b1;
        apply_stimulus(1'b1, 12'h000, 3'd0, 1'b0);
        bus.video_off  = 1'b0;
        bus.overlay_rgb = 12'hF0F;
        bus.overlay_en  = 1'b1;
        apply_stimulus(1'b1, 12'hF0F, 3'd0, 1'b0);
        bus.overlay_en  = 1'b0;
        bus.overlay_rgb = 12'h5A5;

        $display("[TB] mask latched at frame_start");
        bus.mask_in = 6'b111101;
        apply_stimulus(1'b1, 12'h00F, 3'd1, 1'b1);
        apply_stimulus(1'b1, 12'h00F, 3'd1, 1'b1);
        frame_pulse(8'd1, 12'h00F, 3'd1, 1'b1);
        apply_stimulus(1'b1, 12'hF00, 3'd3, 1'b1);
        apply_stimulus(1'b1, 12'hF00, 3'd3, 1'b1);

        $display("[TB] reset with full pipeline");
        do_reset();
        apply_stimulus(1'b1, 12'h00F, 3'd1, 1'b1);
        apply_stimulus(1'b1, 12'h00F, 3'd1, 1'b1);

        $display("[TB] blink");
        bus.mask_in  = 6'b111111;
        bus.blink_in = 6'b000010;
        for (int k = 1; k <= 16; k++) begin
            hidden = (k > 1) && (((k - 1) >> 3) & 1) == 1;
            frame_pulse(8'(k), hidden ? 12'hF00 : 12'h00F, hidden ? 3'd3 : 3'd1, 1'b1);
            hidden = ((k >> 3) & 1) == 1;
            apply_stimulus(1'b1, hidden ? 12'hF00 : 12'h00F, hidden ? 3'd3 : 3'd1, 1'b1);
        end

        $display("[TB] frame counter wrap under overlay");
        bus.blink_in   = 6'b000000;
        bus.overlay_en = 1'b1;
        for (int k = 17; k <= 256; k++) begin
            bus.video_off = 1'b0;
            frame_pulse(8'(k % 256), 12'h5A5, 3'd0, 1'b0);
            bus.video_off = 1'b1;
            apply_stimulus(1'b1, 12'h000, 3'd0, 1'b0);
        end

        for (int k = 0; k < 4; k++) apply_stimulus(1'b0, 12'h000, 3'd0, 1'b0);
        checks++;
        if (pix_q.size() != 0 || fc_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d pixel and %0d frame expectations left, required 0 and 0",
                     pix_q.size(), fc_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
